// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and PC arithmetic for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} skid buffer catching a returning fetch while ID cannot accept it.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Buffer storage; clear wins over load so a redirect always empties it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= NOP_INST_DEF;
      pc    <= 32'd0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= new_instr;
      pc    <= new_pc;
    end else begin
      valid <= valid;
      instr <= instr;
      pc    <= pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, addr_ok/data_ok fetch FSM, redirect handling and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        redirect;
  logic [31:0] target;
  logic        accept;
  logic        data_in;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        hold_load;
  logic        hold_clear;
  logic        id_from_hold;

  // Redirect selection, request handshake and hold-buffer control.
  always_comb begin
    redirect     = branch_taken | jump;
    target       = branch_taken ? branch_target : jump_target;
    inst_req     = !rst && (state == IF_REQ) && !hold_valid && !redirect;
    inst_addr    = pc;
    accept       = inst_req && inst_addr_ok;
    data_in      = (state == IF_WAIT) && inst_data_ok && !redirect;
    // Data that ID cannot take this cycle is parked rather than lost.
    hold_load    = data_in && (stallD || flushD);
    id_from_hold = hold_valid && !flushD && !stallD && !redirect;
    hold_clear   = redirect || id_from_hold;
  end

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .clear     (hold_clear),
    .load      (hold_load),
    .new_instr (inst_rdata),
    .new_pc    (req_pc),
    .valid     (hold_valid),
    .instr     (hold_instr),
    .pc        (hold_pc)
  );

  // Fetch FSM and PC; a redirect in WAIT turns the in-flight fetch into a stale one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IF_REQ;
      pc     <= RESET_PC;
      req_pc <= 32'd0;
    end else begin
      case (state)
        IF_REQ: begin
          if (redirect) begin
            pc <= target;
          end else if (accept) begin
            req_pc <= pc;
            pc     <= pc_plus4(pc);
            state  <= IF_WAIT;
          end else begin
            pc <= pc;
          end
        end
        IF_WAIT: begin
          if (redirect) begin
            pc <= target;
          end
          if (inst_data_ok) begin
            state <= IF_REQ;
          end else if (redirect) begin
            state <= IF_DROP;
          end else begin
            state <= IF_WAIT;
          end
        end
        IF_DROP: begin
          if (redirect) begin
            pc <= target;
          end
          if (inst_data_ok) begin
            state <= IF_REQ;
          end else begin
            state <= IF_DROP;
          end
        end
        default: begin
          state <= IF_REQ;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall beats load; bubbles keep the old PC fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD   <= NOP_INST;
      pcD      <= 32'd0;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP_INST;
      validD <= 1'b0;
    end else if (stallD) begin
      instrD <= instrD;
      validD <= validD;
    end else if (redirect) begin
      instrD <= NOP_INST;
      validD <= 1'b0;
    end else if (hold_valid) begin
      instrD   <= hold_instr;
      pcD      <= hold_pc;
      pcplus4D <= pc_plus4(hold_pc);
      validD   <= 1'b1;
    end else if (data_in) begin
      instrD   <= inst_rdata;
      pcD      <= req_pc;
      pcplus4D <= pc_plus4(req_pc);
      validD   <= 1'b1;
    end else begin
      instrD <= NOP_INST;
      validD <= 1'b0;
    end
  end

endmodule
